// File: rtl/psg_register_writer_if.sv
// Host-side bus of the PSG register writer: write byte, handshake and register bank outputs.
interface psg_register_writer_if;
  logic [7:0]  data_in;
  logic        wr;
  logic        overrun_clr;
  logic        ready;
  logic [15:0] attn;
  logic [29:0] tone_freq;
  logic [2:0]  noise_ctrl;
  logic        noise_reset;
  logic        overrun;

  modport master (
    output data_in, wr, overrun_clr,
    input  ready, attn, tone_freq, noise_ctrl, noise_reset, overrun
  );

  modport slave (
    input  data_in, wr, overrun_clr,
    output ready, attn, tone_freq, noise_ctrl, noise_reset, overrun
  );
endinterface

// File: rtl/psg_register_writer.sv
// SN76489-style latch/data byte decoder, control register bank and READY handshake.
// Optional sticky overrun flag enabled by defining PSG_OVERRUN_FLAG_EN.
module psg_register_writer #(
  parameter int ATTENUATION_CONTROL_BITS = 4,
  parameter int FREQUENCY_COUNTER_BITS   = 10,
  parameter int NOISE_CONTROL_BITS       = 3,
  parameter int WRITE_CYCLES             = 32
) (
  input logic                clk,
  input logic                reset,
  psg_register_writer_if.slave bus
);

  localparam int CNT_W = $clog2(WRITE_CYCLES + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic       ready_s;
  logic       accept_s;

  logic [3:0][ATTENUATION_CONTROL_BITS-1:0] attn_r;
  logic [3:0][ATTENUATION_CONTROL_BITS-1:0] attn_nxt_s;
  logic [2:0][FREQUENCY_COUNTER_BITS-1:0]   tone_r;
  logic [2:0][FREQUENCY_COUNTER_BITS-1:0]   tone_nxt_s;
  logic [NOISE_CONTROL_BITS-1:0]            noise_r;
  logic [NOISE_CONTROL_BITS-1:0]            noise_nxt_s;
  logic [2:0]  latch_r;
  logic [2:0]  latch_nxt_s;
  logic [2:0]  target_s;
  logic        pulse_r;
  logic        pulse_nxt_s;

  assign accept_s = bus.wr && ready_s;

  // Handshake state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Handshake next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:  state_nxt_s = bus.wr ? S_BUSY : S_IDLE;
      S_BUSY:  state_nxt_s = (cnt_r == CNT_W'(0)) ? S_IDLE : S_BUSY;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state flop, so ready rises with reset
  always_comb begin
    ready_s = 1'b0;
    case (state_r)
      S_IDLE:  ready_s = 1'b1;
      S_BUSY:  ready_s = 1'b0;
      default: ready_s = 1'b1;
    endcase
  end

  // Busy counter: ready stays low for WRITE_CYCLES clocks after an accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= CNT_W'(0);
    end else if (accept_s) begin
      cnt_r <= CNT_W'(WRITE_CYCLES - 1);
    end else if ((state_r == S_BUSY) && (cnt_r != CNT_W'(0))) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Byte decode: a latch byte selects its own target, a data byte reuses the latched one
  always_comb begin
    attn_nxt_s  = attn_r;
    tone_nxt_s  = tone_r;
    noise_nxt_s = noise_r;
    latch_nxt_s = latch_r;
    pulse_nxt_s = 1'b0;
    target_s    = bus.data_in[7] ? bus.data_in[6:4] : latch_r;
    if (accept_s) begin
      if (bus.data_in[7]) begin
        latch_nxt_s = bus.data_in[6:4];
      end else begin
        latch_nxt_s = latch_r;
      end
      if (target_s[0]) begin
        attn_nxt_s[target_s[2:1]] = bus.data_in[3:0];
      end else if (target_s[2:1] == 2'd3) begin
        noise_nxt_s = bus.data_in[2:0];
        pulse_nxt_s = 1'b1;
      end else begin
        for (int i = 0; i < 3; i++) begin
          tone_nxt_s[i] = (target_s[2:1] != 2'(i)) ? tone_r[i] :
                          bus.data_in[7] ? {tone_r[i][9:4], bus.data_in[3:0]} :
                                           {bus.data_in[5:0], tone_r[i][3:0]};
        end
      end
    end else begin
      pulse_nxt_s = 1'b0;
    end
  end

  // Register bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attn_r  <= {4{4'hF}};
      tone_r  <= {3{10'h000}};
      noise_r <= 3'b000;
      latch_r <= 3'b000;
      pulse_r <= 1'b0;
    end else begin
      attn_r  <= attn_nxt_s;
      tone_r  <= tone_nxt_s;
      noise_r <= noise_nxt_s;
      latch_r <= latch_nxt_s;
      pulse_r <= pulse_nxt_s;
    end
  end

  assign bus.ready       = ready_s;
  assign bus.attn        = attn_r;
  assign bus.tone_freq   = tone_r;
  assign bus.noise_ctrl  = noise_r;
  assign bus.noise_reset = pulse_r;

`ifdef PSG_OVERRUN_FLAG_EN
  logic overrun_r;

  // Sticky overrun flag; a new dropped write beats a clear in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_r <= 1'b0;
    end else if (bus.wr && !ready_s) begin
      overrun_r <= 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign bus.overrun = overrun_r;
`else
  logic unused_overrun_clr_s;
  assign unused_overrun_clr_s = bus.overrun_clr;
  assign bus.overrun          = 1'b0;
`endif

endmodule

// File: tb/tb_psg_register_writer.sv
// Directed and randomized check of psg_register_writer against a cycle-level behavioural model.
module tb_psg_register_writer;

  localparam int WC = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  psg_register_writer_if bus ();

  psg_register_writer #(.WRITE_CYCLES(WC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [3:0] m_attn [4];
  logic [9:0] m_tone [3];
  logic [2:0] m_noise;
  logic [1:0] m_lch;
  logic       m_lvol;
  int         m_busy;
  logic       m_ovr;
  logic       m_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_attn[i] = 4'hF;
    for (int i = 0; i < 3; i++) m_tone[i] = 10'd0;
    m_noise = 3'd0;
    m_lch   = 2'd0;
    m_lvol  = 1'b0;
    m_busy  = 0;
    m_ovr   = 1'b0;
    m_pulse = 1'b0;
  endtask

  task automatic model_edge(input logic w, input logic [7:0] d, input logic c);
    logic       acc;
    logic [1:0] ch;
    logic       vol;
    acc     = w && (m_busy == 0);
    m_pulse = 1'b0;
`ifdef PSG_OVERRUN_FLAG_EN
    if (w && m_busy != 0) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
`endif
    if (m_busy != 0) m_busy = m_busy - 1;
    if (acc) begin
      m_busy = WC;
      if (d[7]) begin
        m_lch  = d[6:5];
        m_lvol = d[4];
      end
      ch  = m_lch;
      vol = m_lvol;
      if (vol) m_attn[ch] = d[3:0];
      else if (ch == 2'd3) begin
        m_noise = d[2:0];
        m_pulse = 1'b1;
      end else if (d[7]) m_tone[ch] = (m_tone[ch] & 10'h3F0) | 10'(d[3:0]);
      else m_tone[ch] = (m_tone[ch] & 10'h00F) | (10'(d[5:0]) << 4);
    end
  endtask

  task automatic check_all();
    check("attn", 32'(bus.attn), 32'({m_attn[3], m_attn[2], m_attn[1], m_attn[0]}));
    check("tone_freq", 32'(bus.tone_freq), 32'({m_tone[2], m_tone[1], m_tone[0]}));
    check("noise_ctrl", 32'(bus.noise_ctrl), 32'(m_noise));
    check("noise_reset", 32'(bus.noise_reset), 32'(m_pulse));
    check("ready", 32'(bus.ready), 32'(m_busy == 0));
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic c);
    bus.wr          = w;
    bus.data_in     = d;
    bus.overrun_clr = c;
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(w, d, c);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready && n < 100) begin
      n++;
      step(1'b0, 8'h00, 1'b0);
    end
    check("ready_wait_bound", 32'(bus.ready), 32'd1);
  endtask

  task automatic write_byte(input logic [7:0] d);
    int n;
    wait_ready(n);
    step(1'b1, d, 1'b0);
  endtask

  logic exp_ovr;
  int   n;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.wr = 1'b0;
    bus.data_in = 8'h00;
    bus.overrun_clr = 1'b0;
`ifdef PSG_OVERRUN_FLAG_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    model_reset();
    repeat (2) @(negedge clk);

    // 1: reset state
    check_all();
    check("reset_attn", 32'(bus.attn), 32'h0000FFFF);
    reset = 1'b0;

    // 2: tone0 low nibble then high six bits, ready low 32 clocks each
    step(1'b1, 8'h8E, 1'b0);
    wait_ready(n);
    check("ready_low_cycles_latch", n, 32'd32);
    step(1'b1, 8'h0F, 1'b0);
    check("tone0_0FE", 32'(bus.tone_freq[9:0]), 32'h0FE);
    wait_ready(n);
    check("ready_low_cycles_data", n, 32'd32);

    // 3: volume latch then data byte
    write_byte(8'hB5);
    check("attn1_5", 32'(bus.attn[7:4]), 32'h5);
    write_byte(8'h0A);
    check("attn1_A", 32'(bus.attn[7:4]), 32'hA);
    check("tone1_unchanged", 32'(bus.tone_freq[19:10]), 32'h000);

    // 4: noise writes pulse noise_reset for one clock
    write_byte(8'hE6);
    check("noise_110", 32'(bus.noise_ctrl), 32'h6);
    check("noise_pulse1", 32'(bus.noise_reset), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    check("noise_pulse1_end", 32'(bus.noise_reset), 32'd0);
    write_byte(8'h03);
    check("noise_011", 32'(bus.noise_ctrl), 32'h3);
    check("noise_pulse2", 32'(bus.noise_reset), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    check("noise_pulse2_end", 32'(bus.noise_reset), 32'd0);

    // 5: dropped write, overrun set wins over clear
    write_byte(8'h9F);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h90, 1'b0);
    check("attn0_kept", 32'(bus.attn[3:0]), 32'hF);
    check("overrun_set", 32'(bus.overrun), 32'(exp_ovr));
    step(1'b1, 8'h90, 1'b1);
    check("overrun_set_wins", 32'(bus.overrun), 32'(exp_ovr));
    wait_ready(n);
    step(1'b0, 8'h00, 1'b1);
    check("overrun_cleared", 32'(bus.overrun), 32'd0);

    // Randomized traffic, then wr held high
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 140; i++) begin
      step(1'b1, 8'($urandom), 1'b0);
    end
    check("held_wr_busy", 32'(m_busy <= WC), 32'd1);

    // 6: asynchronous reset at busy count 10
    write_byte(8'h85);
    repeat (21) step(1'b0, 8'h00, 1'b0);
    check("busy_before_reset", 32'(bus.ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_ready", 32'(bus.ready), 32'd1);
    check_all();
    @(negedge clk);
    reset = 1'b0;
    write_byte(8'hC7);
    check("after_reset_tone2", 32'(bus.tone_freq[29:20]), 32'h007);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
